noc_packet_arbiter: RTL

- Round-robin arbiter that shares one 24-bit packet register stage between NUM_REQ requesters in the DisplayDecoderNoC fabric.
- Each requester offers a packet under a valid/ready handshake. The winner's packet is captured into a one-entry output register and held until the downstream decoder accepts it.
- The block also tags each captured packet with the index of the requester that sent it, so the decoder knows its source.

---
 rtl/noc_pkg.sv | 36 +++
 rtl/noc_rr_picker.sv | 22 ++
 rtl/noc_packet_arbiter.sv | 71 +++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared constants, types and the round-robin pick function for the
// DisplayDecoderNoC packet arbiter.
package noc_pkg;

  localparam int PKT_W     = 24;
  localparam int NIBBLE_W  = 4;
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef logic [PKT_W-1:0] packet_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... modulo num_req; the first valid requester wins.
  // ptr < num_req always holds, so a single conditional subtract wraps.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int                   num_req);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= num_req) j = j - num_req;
      if (k < num_req && !res.found && valid[j[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// Combinational rotate/priority-encode of the request vector, starting at ptr.
module noc_rr_picker
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), MAX_IDX_W'(ptr), NUM_REQ);
    found = pick.found;
    idx   = IDX_W'(pick.idx);
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Round-robin arbiter feeding a one-entry output register; each held packet
// is tagged with the index of the requester that supplied it.
module noc_packet_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*PKT_W-1:0] in_packet,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_valid,
  output logic [PKT_W-1:0]         out_packet,
  output logic [IDX_W-1:0]         out_src,
  input  logic                     out_ready
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             win_found;
  logic             load_en;
  logic             xfer;
  packet_t          pkt_slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign pkt_slice[i] = in_packet[i*PKT_W +: PKT_W];
  end

  noc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid (in_valid),
    .ptr   (rr_ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  // clear_n gates grants combinationally so nothing is offered during reset.
  assign load_en  = clear_n && enable && (!out_valid || out_ready);
  assign xfer     = load_en && win_found;
  assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    // NOTE: default every combinational output first so no latch is inferred.
    in_ready = '0;
    if (xfer) in_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    // NOTE: state uses non-blocking assignments so all registers update together.
    if (!clear_n) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_packet <= pkt_slice[win_idx];
      out_src    <= win_idx;
      rr_ptr     <= next_ptr;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
